// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Run-time writer for program memory. Packs a big-endian byte
//             stream into I_SIZE-bit instructions, writes them at
//             incrementing addresses from 0, holds the core in reset while
//             loading and pulses done when the last word has been written.
//  Revision : 1.0  initial release
// ============================================================================
module program_loader #(
  parameter int I_SIZE = 24,
  parameter int P_SIZE = 6
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              startIn,
  input  logic [P_SIZE-1:0] lengthIn,
  input  logic              abortIn,
  input  logic [7:0]        byteIn,
  input  logic              byteValidIn,
  output logic              byteReadyOut,
  output logic              writeEnableOut,
  output logic [P_SIZE-1:0] writeAddressOut,
  output logic [I_SIZE-1:0] writeDataOut,
  output logic              cpuHoldOut,
  output logic              doneOut
);

  localparam int BYTES  = (I_SIZE + 7) / 8;
  localparam int WORD_W = BYTES * 8;
  localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [P_SIZE-1:0] length;
  logic [P_SIZE-1:0] addr;
  logic [CNT_W-1:0]  byte_cnt;
  logic [WORD_W-1:0] word;
  logic              accept;
  logic              last_byte;
  logic              final_word;

  // Ready is decoded from state, so a transfer is simply valid while in RECV.
  assign accept     = (state == S_RECV) && byteValidIn;
  assign last_byte  = accept && (byte_cnt == LAST_CNT);
  // length of 0 means a full memory: length-1 wraps to the top address.
  assign final_word = (addr == (length - P_SIZE'(1)));

  // Only the first BYTES-1 bytes need storing; the last one is taken
  // straight off the bus on the edge that completes the word.
  generate
    if (BYTES > 1) begin : g_shreg
      logic [WORD_W-9:0] shreg;

      assign word = {shreg, byteIn};

      // Shift each accepted byte in at the LS end (big-endian assembly).
      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          shreg <= '0;
        end else if (accept) begin
          shreg <= word[WORD_W-9:0];
        end
      end
    end else begin : g_single
      assign word = byteIn;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides progress in RECV and WRITE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (startIn) state_next = S_RECV;
      S_RECV: begin
        if (abortIn)        state_next = S_IDLE;
        else if (last_byte) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (abortIn)         state_next = S_IDLE;
        else if (final_word) state_next = S_DONE;
        else                 state_next = S_RECV;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Control outputs decoded from state only.
  always_comb begin
    byteReadyOut   = (state == S_RECV);
    writeEnableOut = (state == S_WRITE);
    cpuHoldOut     = (state != S_IDLE);
    doneOut        = (state == S_DONE);
  end

  // Length/address/byte counters and the registered write address/data.
  // The write bus is captured on the completing edge so it is valid for
  // the whole WRITE cycle and then holds its value afterwards.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      length          <= '0;
      addr            <= '0;
      byte_cnt        <= '0;
      writeAddressOut <= '0;
      writeDataOut    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (startIn) begin
            length   <= lengthIn;
            addr     <= '0;
            byte_cnt <= '0;
          end
        end
        S_RECV: begin
          if (accept) begin
            byte_cnt <= last_byte ? '0 : byte_cnt + CNT_W'(1);
            if (last_byte && !abortIn) begin
              writeAddressOut <= addr;
              writeDataOut    <= word[I_SIZE-1:0];
            end
          end
        end
        S_WRITE: begin
          if (!abortIn && !final_word) begin
            addr <= addr + P_SIZE'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
